// File: rtl/regfile_sb_pkg.sv
// Shared widths, register count and index type for the scoreboarded register file.
package regfile_sb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_reg32.sv
// Single register with load enable and asynchronous active-low clear.
module reg32
    import regfile_sb_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/regfile_sb.sv
// MIPS register file with busy-bit scoreboard; $0 reads zero and is never busy.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_issue,
    input  logic [ADDR_W-1:0] ctrl_issueReg,
    output logic              busy_A,
    output logic              busy_B
);
    localparam int N = 2**ADDR_W;

    logic [N-1:0]             wr_en;
    logic [N-1:0]             iss_en;
    logic [N-1:0][DATA_W-1:0] rf;
    logic [N-1:1]             busy_q;
    logic [N-1:0]             busy;

    always_comb begin
        wr_en  = '0;
        iss_en = '0;
        if (ctrl_writeEnable) wr_en[ctrl_writeReg]  = 1'b1;
        if (ctrl_issue)       iss_en[ctrl_issueReg] = 1'b1;
        wr_en[REG_ZERO]  = 1'b0;
        iss_en[REG_ZERO] = 1'b0;
    end

    assign rf[REG_ZERO] = '0;

    for (genvar k = 1; k < N; k++) begin : g_reg
        reg32 #(.W(DATA_W)) u_reg (
            .clock (clock),
            .rst_n (ctrl_reset_n),
            .ld    (wr_en[k]),
            .d     (data_writeReg),
            .q     (rf[k])
        );
    end

    // Set is applied after clear so a same-cycle issue outranks the retiring writer.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) busy_q <= '0;
        else               busy_q <= (busy_q & ~wr_en[N-1:1]) | iss_en[N-1:1];
    end

    assign busy = {busy_q, 1'b0};

`ifdef REGFILE_BYPASS_EN
    logic byp_a, byp_b;

    // Gated by reset so outputs stay zero while reset is held.
    assign byp_a = ctrl_reset_n && ctrl_writeEnable &&
                   (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != ADDR_W'(REG_ZERO));
    assign byp_b = ctrl_reset_n && ctrl_writeEnable &&
                   (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != ADDR_W'(REG_ZERO));

    assign data_readRegA = byp_a ? data_writeReg : rf[ctrl_readRegA];
    assign data_readRegB = byp_b ? data_writeReg : rf[ctrl_readRegB];
    assign busy_A        = byp_a ? 1'b0 : busy[ctrl_readRegA];
    assign busy_B        = byp_b ? 1'b0 : busy[ctrl_readRegB];
`else
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];
    assign busy_A        = busy[ctrl_readRegA];
    assign busy_B        = busy[ctrl_readRegB];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, corner sequences, randomized model check.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_readRegA, data_readRegB;
    logic        ctrl_issue;
    logic [4:0]  ctrl_issueReg;
    logic        busy_A, busy_B;

    int nvec = 0;
    int nerr = 0;

    regfile_sb dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_issue       (ctrl_issue),
        .ctrl_issueReg    (ctrl_issueReg),
        .busy_A           (busy_A),
        .busy_B           (busy_B)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        reg_idx_t    wreg;
        logic [31:0] wdata;
        reg_idx_t    ra, rb;
        logic        iss;
        reg_idx_t    ireg;
        logic [31:0] exp_a, exp_b;
        logic        exp_ba, exp_bb;
    } vec_t;

    vec_t tbl[11];

    // Reference state: plain arrays updated from the architectural rules.
    logic [31:0] mreg [32];
    logic        mbusy[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input reg_idx_t wreg, input logic [31:0] wd,
                         input reg_idx_t ra, input reg_idx_t rb,
                         input logic iss, input reg_idx_t ireg);
        ctrl_writeEnable = we;  ctrl_writeReg = wreg; data_writeReg = wd;
        ctrl_readRegA    = ra;  ctrl_readRegB = rb;
        ctrl_issue       = iss; ctrl_issueReg = ireg;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    endtask

    task automatic model_step();
        if (ctrl_writeEnable && ctrl_writeReg != 0) begin
            mreg[ctrl_writeReg]  = data_writeReg;
            mbusy[ctrl_writeReg] = 1'b0;
        end
        if (ctrl_issue && ctrl_issueReg != 0) mbusy[ctrl_issueReg] = 1'b1;
    endtask

    function automatic logic [31:0] model_rd(input reg_idx_t r);
        if (r == 0) return '0;
        if (BYP && ctrl_writeEnable && ctrl_writeReg == r) return data_writeReg;
        return mreg[r];
    endfunction

    function automatic logic model_busy(input reg_idx_t r);
        if (r == 0) return 1'b0;
        if (BYP && ctrl_writeEnable && ctrl_writeReg == r) return 1'b0;
        return mbusy[r];
    endfunction

    initial begin
        // we wreg wdata ra rb iss ireg | exp_a exp_b busyA busyB
        tbl[0]  = '{0, 0, 32'h0,        0, 31, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[1]  = '{1, 5, 32'hDEADBEEF, 1, 2,  0, 0, 32'h0, 32'h0, 0, 0};
        tbl[2]  = '{1, 0, 32'h1234,     5, 5,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[3]  = '{0, 0, 32'h0,        0, 5,  1, 7, 32'h0, 32'hDEADBEEF, 0, 0};
        tbl[4]  = '{0, 0, 32'h0,        7, 7,  0, 0, 32'h0, 32'h0, 1, 1};
        tbl[5]  = '{1, 7, 32'hA5A5A5A5, 7, 5,  0, 0,
                    BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF, !BYP, 0};
        tbl[6]  = '{1, 9, 32'h11,       7, 9,  1, 9,
                    32'hA5A5A5A5, BYP ? 32'h11 : 32'h0, 0, 0};
        tbl[7]  = '{0, 0, 32'h0,        9, 9,  0, 0, 32'h11, 32'h11, 1, 1};
        tbl[8]  = '{1, 3, 32'hCAFEF00D, 3, 9,  1, 0,
                    BYP ? 32'hCAFEF00D : 32'h0, 32'h11, 0, 1};
        tbl[9]  = '{0, 0, 32'h0,        3, 0,  1, 0, 32'hCAFEF00D, 32'h0, 0, 0};
        tbl[10] = '{0, 0, 32'h0,        0, 0,  0, 0, 32'h0, 32'h0, 0, 0};

        ctrl_reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_dataA", data_readRegA, 32'h0);
        chk("reset_busyA", {31'b0, busy_A}, 32'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Directed table: one row per clock.
        for (int i = 0; i < 11; i++) begin
            @(posedge clock); #1;
            drive(tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].ra, tbl[i].rb, tbl[i].iss, tbl[i].ireg);
            @(negedge clock);
            chk($sformatf("tbl%0d_dataA", i), data_readRegA, tbl[i].exp_a);
            chk($sformatf("tbl%0d_dataB", i), data_readRegB, tbl[i].exp_b);
            chk($sformatf("tbl%0d_busyA", i), {31'b0, busy_A}, {31'b0, tbl[i].exp_ba});
            chk($sformatf("tbl%0d_busyB", i), {31'b0, busy_B}, {31'b0, tbl[i].exp_bb});
        end

        // Async reset mid-cycle while a write to $12 and an issue to $12 are pending.
        @(posedge clock); #1;
        drive(1, 12, 32'h7777_0012, 12, 3, 1, 12);
        #2 ctrl_reset_n = 1'b0;
        #1;
        chk("midrst_dataB", data_readRegB, 32'h0);
        @(posedge clock);
        @(negedge clock);
        drive(0, 0, 0, 12, 12, 0, 0);
        ctrl_reset_n = 1'b1;
        #1;
        chk("midrst_reg12", data_readRegA, 32'h0);
        chk("midrst_busy12", {31'b0, busy_B}, 32'h0);
        @(posedge clock); #1;
        chk("midrst_reg12_after", data_readRegA, 32'h0);

        // Randomized traffic against the reference model; narrow index range forces collisions.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            drive($urandom_range(0, 1), reg_idx_t'($urandom_range(0, 7)), $urandom,
                  reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0, reg_idx_t'($urandom_range(0, 7)));
            if (c % 4 == 3) ctrl_readRegB = ctrl_readRegA;
            @(negedge clock);
            chk("rnd_dataA", data_readRegA, model_rd(ctrl_readRegA));
            chk("rnd_dataB", data_readRegB, model_rd(ctrl_readRegB));
            chk("rnd_busyA", {31'b0, busy_A}, {31'b0, model_busy(ctrl_readRegA)});
            chk("rnd_busyB", {31'b0, busy_B}, {31'b0, model_busy(ctrl_readRegB)});
            @(posedge clock);
            model_step();
        end

        // Reset held after random writes: every index reads zero and idle.
        #3;
        ctrl_reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 32; r++) begin
            ctrl_readRegA = reg_idx_t'(r);
            ctrl_readRegB = reg_idx_t'(31 - r);
            #1;
            chk($sformatf("hold_dataA%0d", r), data_readRegA, 32'h0);
            chk($sformatf("hold_dataB%0d", r), data_readRegB, 32'h0);
            chk($sformatf("hold_busy%0d", r), {30'b0, busy_A, busy_B}, 32'h0);
        end
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
